// File: rtl/display_pkg.sv
// Segment patterns shared by the display multiplexer and its decoder.
// Patterns are {a,b,c,d,e,f,g}, active low.
package display_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b1100000;
   localparam logic [6:0] SEG_C     = 7'b0110001;
   localparam logic [6:0] SEG_D     = 7'b1000010;
   localparam logic [6:0] SEG_E     = 7'b0110000;
   localparam logic [6:0] SEG_F     = 7'b0111000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] CODE_ZERO = 4'd0;

endpackage

// File: rtl/seg_decoder.sv
// Combinational 4-bit code to active-low seven-segment pattern.
// Codes 10..15 show A..F only when hex mode is selected, otherwise blank.
module seg_decoder
   import display_pkg::*;
(
   input  logic [3:0] i_code,
   input  logic       i_hex_mode,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      case (i_code)
         4'd0:  o_seg = SEG_0;
         4'd1:  o_seg = SEG_1;
         4'd2:  o_seg = SEG_2;
         4'd3:  o_seg = SEG_3;
         4'd4:  o_seg = SEG_4;
         4'd5:  o_seg = SEG_5;
         4'd6:  o_seg = SEG_6;
         4'd7:  o_seg = SEG_7;
         4'd8:  o_seg = SEG_8;
         4'd9:  o_seg = SEG_9;
         4'd10: o_seg = i_hex_mode ? SEG_A : SEG_BLANK;
         4'd11: o_seg = i_hex_mode ? SEG_B : SEG_BLANK;
         4'd12: o_seg = i_hex_mode ? SEG_C : SEG_BLANK;
         4'd13: o_seg = i_hex_mode ? SEG_D : SEG_BLANK;
         4'd14: o_seg = i_hex_mode ? SEG_E : SEG_BLANK;
         4'd15: o_seg = i_hex_mode ? SEG_F : SEG_BLANK;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/display_mux.sv
// Time-multiplexed seven-segment driver: shadow-registered digits, scanned
// one slot per PRESCALE cycles, with optional leading-zero suppression.
module display_mux
   import display_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 50000,
   parameter int HEX_MODE = 0
)(
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_enable,
   input  logic                  i_load,
   input  logic [4*DIGITS-1:0]   i_value,
   input  logic [DIGITS-1:0]     i_dp_in,
   input  logic                  i_blank_lz,
   output logic [6:0]            o_seg,
   output logic                  o_dp_n,
   output logic [DIGITS-1:0]     o_an_n
);

   localparam int PW = $clog2(PRESCALE);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [4*DIGITS-1:0] r_value;
   logic [DIGITS-1:0]   r_dp;
   logic [PW-1:0]       r_presc;
   logic [IW-1:0]       r_index;
   logic [6:0]          r_seg;
   logic                r_dp_n;
   logic [DIGITS-1:0]   r_an_n;

   logic                w_wrap;
   logic                w_zero_run;
   logic [DIGITS-1:0]   w_lz;
   logic [3:0]          w_code;
   logic                w_dp;
   logic                w_sel_lz;
   logic [DIGITS-1:0]   w_an;
   logic [6:0]          w_dec;

   assign w_wrap = (r_presc == PW'(PRESCALE - 1));

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_value <= '0;
         r_dp    <= '0;
         r_presc <= '0;
         r_index <= '0;
      end else begin
         if (i_load) begin
            r_value <= i_value;
            r_dp    <= i_dp_in;
         end
         if (i_enable) begin
            if (w_wrap) begin
               r_presc <= '0;
               r_index <= (r_index == IW'(DIGITS - 1)) ? '0 : r_index + IW'(1);
            end else begin
               r_presc <= r_presc + PW'(1);
            end
         end
      end
   end

   // w_lz[i] is set when digit i and every digit above it hold code zero.
   always_comb begin
      w_lz       = '0;
      w_zero_run = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         w_zero_run = w_zero_run && (r_value[4*i +: 4] == CODE_ZERO);
         w_lz[i]    = w_zero_run;
      end
   end

   always_comb begin
      w_code   = r_value[3:0];
      w_dp     = r_dp[0];
      w_sel_lz = 1'b0;
      w_an     = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_index == IW'(i)) begin
            w_code   = r_value[4*i +: 4];
            w_dp     = r_dp[i];
            w_sel_lz = (i > 0) && w_lz[i];
            w_an[i]  = 1'b0;
         end
      end
   end

   seg_decoder u_seg_decoder (
      .i_code     (w_code),
      .i_hex_mode (HEX_MODE != 0),
      .o_seg      (w_dec)
   );

   // Anode stays low for a suppressed digit; only the segments go blank.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_seg  <= SEG_BLANK;
         r_dp_n <= 1'b1;
         r_an_n <= '1;
      end else if (!i_enable) begin
         r_seg  <= SEG_BLANK;
         r_dp_n <= 1'b1;
         r_an_n <= '1;
      end else begin
         r_seg  <= (i_blank_lz && w_sel_lz) ? SEG_BLANK : w_dec;
         r_dp_n <= ~w_dp;
         r_an_n <= w_an;
      end
   end

   assign o_seg  = r_seg;
   assign o_dp_n = r_dp_n;
   assign o_an_n = r_an_n;

endmodule
